// File: rtl/bp_fetch_ctrl_pkg.sv
// bp_fetch_ctrl_pkg
//   Shared definitions for the fetch-stage branch predictor. These include
//   the address/table geometry, the 2-bit counter encoding, the BTB entry
//   layout and the value that the table and the prediction pipe return to
//   on reset.
package bp_fetch_ctrl_pkg;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  // Each tag holds the PC bits that sit above the index and the word offset.
  localparam int TAG_W   = XLEN - IDX_W - 2;

  // 2-bit saturating counter states. Bit 1 set means "predict taken".
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam logic [XLEN-1:0] RESET_TARGET = '0;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
  } btbEntry_t;

  localparam btbEntry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: RESET_TARGET, ctr: SNT};

  // Move the counter one step toward the resolved direction. The counter
  // stays put once it reaches either end.
  function automatic logic [1:0] ctrStep(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_fetch_ctrl_btb_table.sv
// bp_fetch_ctrl_btb_table
//   Direct-mapped BTB storage. It has two combinational read ports and one
//   synchronous write port. Reset clears every entry asynchronously, so the
//   table is built from registers and not from block RAM.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   rdIdxF/rdEntryF - fetch-stage lookup
//   rdIdxE/rdEntryE - execute-stage lookup (hit check for the update)
//   wrEn/wrIdx/wrEntry - entry write at the rising edge
module bp_fetch_ctrl_btb_table
  import bp_fetch_ctrl_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rdIdxF,
  output btbEntry_t        rdEntryF,
  input  logic [IDX_W-1:0] rdIdxE,
  output btbEntry_t        rdEntryE,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  btbEntry_t        wrEntry
);

  btbEntry_t tbl [ENTRIES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= RESET_ENTRY;
    end else if (wrEn) begin
      tbl[wrIdx] <= wrEntry;
    end
  end

  // The fetch port reads the contents from before any write in the same
  // cycle. There is no write-to-read bypass.
  assign rdEntryF = tbl[rdIdxF];
  assign rdEntryE = tbl[rdIdxE];

endmodule

// File: rtl/bp_fetch_ctrl.sv
// bp_fetch_ctrl
//   Branch prediction and redirect control for the fetch stage. In F it looks
//   up the BTB and predicts the next PC. It carries the prediction with the
//   instruction through D and E and resolves it in E. On a misprediction it
//   redirects fetch and squashes D and E.
// Ports:
//   clk, rst (async, active-low)
//   PCF, StallD, FlushE_in                 - fetch PC and hazard-unit controls
//   PCE, BranchE, TakenE, PCTargetE        - resolution info from E
//   NextPCF, PredTakenF                    - next fetch PC and the F prediction
//   MispredictE, FlushD, FlushE            - redirect and squash requests
//   BrCount, MissCount                     - saturating statistics counters
module bp_fetch_ctrl
  import bp_fetch_ctrl_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PCF,
  input  logic            StallD,
  input  logic            FlushE_in,
  input  logic [XLEN-1:0] PCE,
  input  logic            BranchE,
  input  logic            TakenE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] NextPCF,
  output logic            PredTakenF,
  output logic            MispredictE,
  output logic            FlushD,
  output logic            FlushE,
  output logic [31:0]     BrCount,
  output logic [31:0]     MissCount
);

  localparam int TW = XLEN - IDX_W - 2;

  logic [IDX_W-1:0] idxF, idxE;
  logic [TW-1:0]    tagF, tagE;
  btbEntry_t        entryF, entryE, wrEntry;
  logic             wrEn, hitF, hitE;
  logic [XLEN-1:0]  predTargetF, predTargetD, predTargetE, redirectPc;
  logic             predTakenD, predTakenE, mispredictRaw;

  assign idxF = PCF[IDX_W+1:2];
  assign tagF = PCF[XLEN-1:IDX_W+2];
  assign idxE = PCE[IDX_W+1:2];
  assign tagE = PCE[XLEN-1:IDX_W+2];

  bp_fetch_ctrl_btb_table #(
    .ENTRIES(ENTRIES),
    .IDX_W  (IDX_W)
  ) uTable (
    .clk     (clk),
    .rst     (rst),
    .rdIdxF  (idxF),
    .rdEntryF(entryF),
    .rdIdxE  (idxE),
    .rdEntryE(entryE),
    .wrEn    (wrEn),
    .wrIdx   (idxE),
    .wrEntry (wrEntry)
  );

  // F lookup
  assign hitF        = entryF.valid & (entryF.tag == tagF);
  assign PredTakenF  = hitF & entryF.ctr[1];
  assign predTargetF = entryF.target;

  // E resolution
  always_comb begin
    mispredictRaw = predTakenE;
    if (BranchE)
      mispredictRaw = (TakenE != predTakenE) |
                      (TakenE & predTakenE & (PCTargetE != predTargetE));
  end

  // The prediction pipe is already clear during reset. A taken branch that is
  // still presented in E would look like a mispredict, so the resolution is
  // held off until reset is released.
  assign MispredictE = rst & mispredictRaw;
  assign redirectPc  = (BranchE & TakenE) ? PCTargetE : PCE + XLEN'(4);
  assign FlushD      = MispredictE;
  assign FlushE      = MispredictE | FlushE_in;

  always_comb begin
    if (MispredictE)     NextPCF = redirectPc;
    else if (PredTakenF) NextPCF = predTargetF;
    else                 NextPCF = PCF + XLEN'(4);
  end

  // Prediction pipe F -> D -> E. A flush has priority over a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      predTakenD  <= 1'b0;
      predTargetD <= RESET_TARGET;
      predTakenE  <= 1'b0;
      predTargetE <= RESET_TARGET;
    end else begin
      if (FlushD) begin
        predTakenD  <= 1'b0;
        predTargetD <= RESET_TARGET;
      end else if (!StallD) begin
        predTakenD  <= PredTakenF;
        predTargetD <= predTargetF;
      end
      if (FlushE) begin
        predTakenE  <= 1'b0;
        predTargetE <= RESET_TARGET;
      end else begin
        predTakenE  <= predTakenD;
        predTargetE <= predTargetD;
      end
    end
  end

  // Table update at PCE. The hit is checked again against the table here
  // rather than carried down the pipe. Aliasing cleanup only fires when a
  // non-branch arrived with a taken prediction. Bubbles in E carry
  // PredTakenE=0 and a garbage PCE, so they never disturb the table.
  assign hitE = entryE.valid & (entryE.tag == tagE);

  always_comb begin
    wrEn    = 1'b0;
    wrEntry = entryE;
    if (BranchE) begin
      if (hitE) begin
        wrEn        = 1'b1;
        wrEntry.ctr = ctrStep(entryE.ctr, TakenE);
        if (TakenE) wrEntry.target = PCTargetE;
      end else if (TakenE) begin
        wrEn           = 1'b1;
        wrEntry.valid  = 1'b1;
        wrEntry.tag    = tagE;
        wrEntry.target = PCTargetE;
        wrEntry.ctr    = WT;
      end
    end else if (hitE && predTakenE) begin
      wrEn          = 1'b1;
      wrEntry.valid = 1'b0;
    end
  end

  // Statistics counters. They stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      BrCount   <= '0;
      MissCount <= '0;
    end else begin
      if (BranchE && (BrCount != 32'hFFFF_FFFF))       BrCount   <= BrCount + 32'd1;
      if (MispredictE && (MissCount != 32'hFFFF_FFFF)) MissCount <= MissCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_bp_fetch_ctrl.sv
module tb_bp_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PCE, PCTargetE;
  logic        StallD, FlushE_in, BranchE, TakenE;
  logic [31:0] NextPCF, BrCount, MissCount;
  logic        PredTakenF, MispredictE, FlushD, FlushE;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  always #5 clk = ~clk;

  bp_fetch_ctrl dut (
    .clk(clk), .rst(rst), .PCF(PCF), .StallD(StallD), .FlushE_in(FlushE_in),
    .PCE(PCE), .BranchE(BranchE), .TakenE(TakenE), .PCTargetE(PCTargetE),
    .NextPCF(NextPCF), .PredTakenF(PredTakenF), .MispredictE(MispredictE),
    .FlushD(FlushD), .FlushE(FlushE), .BrCount(BrCount), .MissCount(MissCount)
  );

  // ---------------- behavioural reference model ----------------
  bit          mValid [16];
  int          mCtr   [16];
  logic [31:0] mTag   [16];
  logic [31:0] mTarget[16];
  bit          mPdT, mPeT;
  logic [31:0] mPdTgt, mPeTgt, mBr, mMiss;
  bit          ePredF, eMis, eFD, eFE;
  logic [31:0] eTgtF, eNext;

  function automatic void resetModel();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 0; mCtr[i] = 0; mTag[i] = 0; mTarget[i] = 0;
    end
    mPdT = 0; mPeT = 0; mPdTgt = 0; mPeTgt = 0; mBr = 0; mMiss = 0;
  endfunction

  function automatic void evalModel();
    int fi;
    logic [31:0] redir;
    fi     = int'(PCF[5:2]);
    ePredF = mValid[fi] && (mTag[fi] == (PCF >> 6)) && (mCtr[fi] >= 2);
    eTgtF  = mTarget[fi];
    if (!rst)         eMis = 0;
    else if (BranchE) eMis = (TakenE != mPeT) || (TakenE && mPeT && (PCTargetE != mPeTgt));
    else              eMis = mPeT;
    redir = (BranchE && TakenE) ? PCTargetE : PCE + 32'd4;
    eNext = eMis ? redir : (ePredF ? eTgtF : PCF + 32'd4);
    eFD   = eMis;
    eFE   = eMis || FlushE_in;
  endfunction

  function automatic void updateModel();
    int  ei;
    bit  hitE;
    bit  newPdT;
    logic [31:0] newPdTgt;
    if (!rst) begin
      resetModel();
      return;
    end
    ei   = int'(PCE[5:2]);
    hitE = mValid[ei] && (mTag[ei] == (PCE >> 6));
    if (BranchE) begin
      if (hitE) begin
        mCtr[ei] = TakenE ? ((mCtr[ei] == 3) ? 3 : mCtr[ei] + 1)
                          : ((mCtr[ei] == 0) ? 0 : mCtr[ei] - 1);
        if (TakenE) mTarget[ei] = PCTargetE;
      end else if (TakenE) begin
        mValid[ei] = 1; mTag[ei] = PCE >> 6; mTarget[ei] = PCTargetE; mCtr[ei] = 2;
      end
    end else if (hitE && mPeT) begin
      mValid[ei] = 0;
    end
    newPdT   = eFD ? 0 : (StallD ? mPdT : ePredF);
    newPdTgt = eFD ? 32'd0 : (StallD ? mPdTgt : eTgtF);
    mPeT     = eFE ? 0 : mPdT;
    mPeTgt   = eFE ? 32'd0 : mPdTgt;
    mPdT     = newPdT;
    mPdTgt   = newPdTgt;
    if (BranchE && mBr != 32'hFFFF_FFFF) mBr = mBr + 1;
    if (eMis && mMiss != 32'hFFFF_FFFF) mMiss = mMiss + 1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [31:0] pcf, input bit br, input bit tk,
                       input logic [31:0] pce, input logic [31:0] tgt);
    PCF = pcf; BranchE = br; TakenE = tk; PCE = pce; PCTargetE = tgt;
    StallD = 0; FlushE_in = 0;
  endtask

  task automatic settle();
    #1;
    evalModel();
  endtask

  task automatic tick();
    evalModel();
    txn++;
    $display("txn %0d rst=%0b PCF=%h PCE=%h br=%0b tk=%0b tgt=%h NextPCF=%h pred=%0b mis=%0b",
             txn, rst, PCF, PCE, BranchE, TakenE, PCTargetE, NextPCF, PredTakenF, MispredictE);
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  // Clears the prediction pipe right after a taken fetch so that it never
  // reaches E with a non-branch.
  task automatic drain();
    drive(32'h300, 0, 0, 32'h900, 32'h0);
    FlushE_in = 1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    drive(32'h0, 1, 1, 32'h10, 32'h40);
    FlushE_in = 1;
    settle();
    checks++; if (PredTakenF !== 1'b0) begin failures++; $display("FAIL rst_pred got=%b exp=0", PredTakenF); end
    checks++; if (NextPCF !== 32'h4) begin failures++; $display("FAIL rst_nextpc got=%h exp=00000004", NextPCF); end
    checks++; if (MispredictE !== 1'b0) begin failures++; $display("FAIL rst_mis got=%b exp=0", MispredictE); end
    checks++; if (FlushD !== 1'b0) begin failures++; $display("FAIL rst_flushd got=%b exp=0", FlushD); end
    checks++; if (FlushE !== 1'b1) begin failures++; $display("FAIL rst_flushe got=%b exp=1", FlushE); end
    checks++; if (BrCount !== 32'd0 || MissCount !== 32'd0) begin
      failures++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", BrCount, MissCount);
    end
    drive(32'h0, 0, 0, 32'h900, 32'h0);
    tick();
    rst = 1;
    drive(32'h0, 0, 0, 32'h900, 32'h0);
    settle();
    checks++; if (NextPCF !== 32'h4 || PredTakenF !== 1'b0) begin
      failures++; $display("FAIL idle_fetch got=%h/%b exp=00000004/0", NextPCF, PredTakenF);
    end
    tick();
  endtask

  task automatic test_taken_cold();
    drive(32'h300, 1, 1, 32'h10, 32'h40);
    settle();
    checks++; if (MispredictE !== 1'b1) begin failures++; $display("FAIL cold_mis got=%b exp=1", MispredictE); end
    checks++; if (NextPCF !== 32'h40) begin failures++; $display("FAIL cold_nextpc got=%h exp=00000040", NextPCF); end
    checks++; if (FlushD !== 1'b1 || FlushE !== 1'b1) begin
      failures++; $display("FAIL cold_flush got=%b%b exp=11", FlushD, FlushE);
    end
    tick();
    drive(32'h10, 0, 0, 32'h900, 32'h0);
    settle();
    checks++; if (PredTakenF !== 1'b1 || NextPCF !== 32'h40) begin
      failures++; $display("FAIL cold_predict got=%b/%h exp=1/00000040", PredTakenF, NextPCF);
    end
    tick();
    drain();
    checks++; if (BrCount !== 32'd1 || MissCount !== 32'd1) begin
      failures++; $display("FAIL cold_counts got=%0d/%0d exp=1/1", BrCount, MissCount);
    end
  endtask

  task automatic test_not_taken();
    drive(32'h10, 0, 0, 32'h900, 32'h0);
    tick();
    drive(32'h10, 1, 0, 32'h10, 32'h0);
    settle();
    checks++; if (MispredictE !== 1'b0) begin failures++; $display("FAIL nt1_mis got=%b exp=0", MispredictE); end
    tick();
    drive(32'h300, 1, 0, 32'h10, 32'h0);
    settle();
    checks++; if (MispredictE !== 1'b1 || NextPCF !== 32'h14 || FlushD !== 1'b1) begin
      failures++; $display("FAIL nt2_redirect got=%b/%h/%b exp=1/00000014/1", MispredictE, NextPCF, FlushD);
    end
    tick();
    drive(32'h10, 0, 0, 32'h900, 32'h0);
    settle();
    checks++; if (PredTakenF !== 1'b0 || NextPCF !== 32'h14) begin
      failures++; $display("FAIL nt_predict got=%b/%h exp=0/00000014", PredTakenF, NextPCF);
    end
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      drive(32'h300, 1, 1, 32'h10, 32'h40);
      settle();
      checks++; if (MispredictE !== 1'b1 || NextPCF !== 32'h40) begin
        failures++; $display("FAIL sat_taken%0d got=%b/%h exp=1/00000040", i, MispredictE, NextPCF);
      end
      tick();
    end
    drive(32'h300, 1, 0, 32'h10, 32'h0);
    settle();
    checks++; if (MispredictE !== 1'b0) begin failures++; $display("FAIL sat_nt_mis got=%b exp=0", MispredictE); end
    tick();
    drive(32'h10, 0, 0, 32'h900, 32'h0);
    settle();
    checks++; if (PredTakenF !== 1'b1 || NextPCF !== 32'h40) begin
      failures++; $display("FAIL sat_predict got=%b/%h exp=1/00000040", PredTakenF, NextPCF);
    end
    tick();
    drain();
  endtask

  task automatic test_aliasing();
    drive(32'h10, 0, 0, 32'h900, 32'h0);
    tick();
    drive(32'h300, 0, 0, 32'h900, 32'h0);
    tick();
    drive(32'h300, 0, 0, 32'h10, 32'h0);
    settle();
    checks++; if (MispredictE !== 1'b1 || NextPCF !== 32'h14 || FlushE !== 1'b1) begin
      failures++; $display("FAIL alias_redirect got=%b/%h/%b exp=1/00000014/1", MispredictE, NextPCF, FlushE);
    end
    tick();
    drive(32'h10, 0, 0, 32'h900, 32'h0);
    settle();
    checks++; if (PredTakenF !== 1'b0) begin failures++; $display("FAIL alias_cleared got=%b exp=0", PredTakenF); end
    tick();
  endtask

  task automatic test_stall();
    drive(32'h300, 1, 1, 32'h10, 32'h40);
    tick();
    drive(32'h10, 0, 0, 32'h900, 32'h0);
    tick();
    drive(32'h300, 0, 0, 32'h900, 32'h0);
    StallD = 1;
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(32'h300, 1, 1, 32'h10, 32'h40);
      settle();
      checks++; if (MispredictE !== 1'b0) begin
        failures++; $display("FAIL stall_hold%0d got=%b exp=0", i, MispredictE);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(32'h300, 1, 1, 32'h500, 32'h80);
    settle();
    checks++; if (MispredictE !== 1'b1) begin failures++; $display("FAIL mid_pre_mis got=%b exp=1", MispredictE); end
    rst = 0;
    #1;
    resetModel();
    evalModel();
    checks++; if (MispredictE !== 1'b0 || FlushD !== 1'b0 || FlushE !== 1'b0) begin
      failures++; $display("FAIL mid_rst_flush got=%b%b%b exp=000", MispredictE, FlushD, FlushE);
    end
    checks++; if (NextPCF !== 32'h304 || BrCount !== 32'd0) begin
      failures++; $display("FAIL mid_rst_state got=%h/%0d exp=00000304/0", NextPCF, BrCount);
    end
    tick();
    rst = 1;
    drive(32'h10, 0, 0, 32'h900, 32'h0);
    settle();
    checks++; if (PredTakenF !== 1'b0 || NextPCF !== 32'h14) begin
      failures++; $display("FAIL mid_rst_miss got=%b/%h exp=0/00000014", PredTakenF, NextPCF);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] tgts[3];
    tgts[0] = 32'h40; tgts[1] = 32'h80; tgts[2] = 32'h100;
    for (int n = 0; n < 200; n++) begin
      PCF       = ($urandom_range(0, 1) << 6) | ($urandom_range(0, 3) << 2);
      PCE       = ($urandom_range(0, 1) << 6) | ($urandom_range(0, 3) << 2);
      BranchE   = 1'($urandom_range(0, 1));
      TakenE    = 1'($urandom_range(0, 1));
      PCTargetE = tgts[$urandom_range(0, 2)];
      StallD    = ($urandom_range(0, 7) == 0);
      FlushE_in = ($urandom_range(0, 7) == 0);
      settle();
      checks++; if (NextPCF !== eNext) begin failures++; $display("FAIL rnd%0d_nextpc got=%h exp=%h", n, NextPCF, eNext); end
      checks++; if (PredTakenF !== ePredF) begin failures++; $display("FAIL rnd%0d_pred got=%b exp=%b", n, PredTakenF, ePredF); end
      checks++; if (MispredictE !== eMis) begin failures++; $display("FAIL rnd%0d_mis got=%b exp=%b", n, MispredictE, eMis); end
      checks++; if (FlushD !== eFD || FlushE !== eFE) begin
        failures++; $display("FAIL rnd%0d_flush got=%b%b exp=%b%b", n, FlushD, FlushE, eFD, eFE);
      end
      checks++; if (BrCount !== mBr || MissCount !== mMiss) begin
        failures++; $display("FAIL rnd%0d_counts got=%0d/%0d exp=%0d/%0d", n, BrCount, MissCount, mBr, mMiss);
      end
      tick();
    end
  endtask

  initial begin
    rst = 0;
    PCF = 0; PCE = 0; PCTargetE = 0;
    StallD = 0; FlushE_in = 0; BranchE = 0; TakenE = 0;
    resetModel();
    test_reset();
    test_taken_cold();
    test_not_taken();
    test_saturation();
    test_aliasing();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
